turn_signal_sequencer: RTL and testbench

Parametrised sequential turn/hazard/brake lamp controller driving a bank of 2×SEG lamps, SEG per side. It is clocked by the divided slow_clk from the clock-divider stage, so one slow_clk edge is one animation tick. The block generalises the fixed 4+4 sweep controller in four ways: configurable lamp count, configurable hazard blink duty, hazard pre-emption of a running sweep, and a brake overlay.

---
 rtl/turn_pkg.sv | 28 ++
 rtl/turn_thermo.sv | 17 +
 rtl/turn_signal_sequencer.sv | 164 ++++++++++++++++
 tb/tb_turn_signal_sequencer.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/turn_pkg.sv
// Shared types and constants for the sequential turn/hazard/brake lamp controller.
// Lamp index convention: position 0 is the innermost lamp of a side.
package turn_pkg;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      LSWP = 3'd1,
      RSWP = 3'd2,
      HON  = 3'd3,
      HOFF = 3'd4
   } state_t;

   typedef enum logic {
      SIDE_RIGHT = 1'b0,
      SIDE_LEFT  = 1'b1
   } side_t;

   localparam int SEG_MIN = 2;
   localparam int SEG_MAX = 16;
   localparam int HAZ_MIN = 1;
   localparam int HAZ_MAX = 15;

   // Left lamps grow upward from led[seg]; right lamps grow downward from led[seg-1].
   function automatic int lamp_idx(input side_t side, input int pos, input int seg);
      return (side == SIDE_LEFT) ? (seg + pos) : (seg - 1 - pos);
   endfunction

endpackage

// File: rtl/turn_thermo.sv
// Combinational thermometer decoder: lights the lowest i_count lamps (inner-first).
module turn_thermo #(
   parameter int SEG = 4,
   parameter int SW  = $clog2(SEG + 1)
) (
   input  logic [SW-1:0]  i_count,
   output logic [SEG-1:0] o_lamps
);

   always_comb begin
      o_lamps = '0;
      for (int i = 0; i < SEG; i++) begin
         o_lamps[i] = (SW'(i) < i_count);
      end
   end

endmodule

// File: rtl/turn_signal_sequencer.sv
// Sequential turn/hazard/brake lamp controller; one slow_clk edge is one animation tick.
// FSM, step/blink counters and brake overlay live here; all outputs are registered.
module turn_signal_sequencer
   import turn_pkg::*;
#(
   parameter int SEG     = 4,
   parameter int HAZ_ON  = 1,
   parameter int HAZ_OFF = 1
) (
   input  logic             slow_clk,
   input  logic             reset,
   input  logic             left,
   input  logic             right,
   input  logic             hazard,
   input  logic             brake,
   output logic [2*SEG-1:0] led,
   output logic             active
);

   localparam int SW = $clog2(SEG + 1);

   generate
      if (SEG < SEG_MIN || SEG > SEG_MAX || HAZ_ON < HAZ_MIN || HAZ_ON > HAZ_MAX ||
          HAZ_OFF < HAZ_MIN || HAZ_OFF > HAZ_MAX) begin : g_bad_param
         $error("turn_signal_sequencer: parameter out of legal range");
      end
   endgenerate

   state_t             r_state;
   logic [SW-1:0]      r_step;
   logic [3:0]         r_blink;
   logic [2*SEG-1:0]   r_led;
   logic               r_active;

   state_t             w_state_nxt;
   logic [SW-1:0]      w_step_nxt;
   logic [3:0]         w_blink_nxt;
   state_t             w_dec_state;
   logic [SW-1:0]      w_dec_step;
   logic [3:0]         w_dec_blink;
   logic               w_haz;
   logic [SEG-1:0]     w_thermo;
   logic [2*SEG-1:0]   w_led_nxt;

   assign w_haz = hazard | (left & right);

   always_comb begin
      w_dec_state = IDLE;
      w_dec_step  = '0;
      w_dec_blink = 4'd0;
      if (w_haz) begin
         w_dec_state = HON;
         w_dec_blink = 4'd1;
      end else if (left) begin
         w_dec_state = LSWP;
         w_dec_step  = SW'(1);
      end else if (right) begin
         w_dec_state = RSWP;
         w_dec_step  = SW'(1);
      end else begin
         w_dec_state = IDLE;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_step_nxt  = r_step;
      w_blink_nxt = r_blink;
      if (reset) begin
         w_state_nxt = IDLE;
         w_step_nxt  = '0;
         w_blink_nxt = 4'd0;
      end else begin
         case (r_state)
            IDLE: begin
               w_state_nxt = w_dec_state;
               w_step_nxt  = w_dec_step;
               w_blink_nxt = w_dec_blink;
            end
            LSWP, RSWP: begin
               // Hazard pre-empts a running sweep; otherwise it always runs to completion.
               if (w_haz) begin
                  w_state_nxt = HON;
                  w_step_nxt  = '0;
                  w_blink_nxt = 4'd1;
               end else if (r_step == SW'(SEG)) begin
                  w_state_nxt = IDLE;
                  w_step_nxt  = '0;
               end else begin
                  w_step_nxt  = r_step + SW'(1);
               end
            end
            HON: begin
               if (r_blink == 4'(HAZ_ON)) begin
                  w_state_nxt = HOFF;
                  w_blink_nxt = 4'd1;
               end else begin
                  w_blink_nxt = r_blink + 4'd1;
               end
            end
            HOFF: begin
               if (r_blink == 4'(HAZ_OFF)) begin
                  w_state_nxt = w_dec_state;
                  w_step_nxt  = w_dec_step;
                  w_blink_nxt = w_dec_blink;
               end else begin
                  w_blink_nxt = r_blink + 4'd1;
               end
            end
            default: begin
               w_state_nxt = IDLE;
               w_step_nxt  = '0;
               w_blink_nxt = 4'd0;
            end
         endcase
      end
   end

   turn_thermo #(.SEG(SEG), .SW(SW)) u_thermo (
      .i_count (w_step_nxt),
      .o_lamps (w_thermo)
   );

   always_comb begin
      w_led_nxt = '0;
      case (w_state_nxt)
         IDLE: w_led_nxt = brake ? '1 : '0;
         LSWP: begin
            for (int i = 0; i < SEG; i++) begin
               w_led_nxt[lamp_idx(SIDE_LEFT, i, SEG)]  = w_thermo[i];
               w_led_nxt[lamp_idx(SIDE_RIGHT, i, SEG)] = brake;
            end
         end
         RSWP: begin
            for (int i = 0; i < SEG; i++) begin
               w_led_nxt[lamp_idx(SIDE_RIGHT, i, SEG)] = w_thermo[i];
               w_led_nxt[lamp_idx(SIDE_LEFT, i, SEG)]  = brake;
            end
         end
         HON:     w_led_nxt = '1;
         default: w_led_nxt = '0;
      endcase
   end

   always_ff @(posedge slow_clk) begin
      if (reset) begin
         r_state  <= IDLE;
         r_step   <= '0;
         r_blink  <= 4'd0;
         r_led    <= '0;
         r_active <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_step   <= w_step_nxt;
         r_blink  <= w_blink_nxt;
         r_led    <= w_led_nxt;
         r_active <= (w_state_nxt != IDLE);
      end
   end

   assign led    = r_led;
   assign active = r_active;

endmodule

// File: tb/tb_turn_signal_sequencer.sv
// Self-checking bench: directed vector table for the lamp scenarios, then random
// stimulus compared against a tick-counting behavioural model.
module tb_turn_signal_sequencer;

   localparam int SEG     = 4;
   localparam int HAZ_ON  = 2;
   localparam int HAZ_OFF = 2;
   localparam int NL      = 2 * SEG;

   logic          slow_clk = 1'b0;
   logic          reset = 1'b1, left = 1'b0, right = 1'b0, hazard = 1'b0, brake = 1'b0;
   logic [NL-1:0] led;
   logic          active;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic          r, l, rt, h, b;
      logic [NL-1:0] exp_led;
      logic          exp_act;
   } vec_t;

   vec_t vecs[$];

   // model: 0 idle, 1 left sweep, 2 right sweep, 3 hazard blink; t = ticks spent in that mode
   int m_mode = 0;
   int m_t    = 0;

   turn_signal_sequencer #(.SEG(SEG), .HAZ_ON(HAZ_ON), .HAZ_OFF(HAZ_OFF)) dut (
      .slow_clk (slow_clk),
      .reset    (reset),
      .left     (left),
      .right    (right),
      .hazard   (hazard),
      .brake    (brake),
      .led      (led),
      .active   (active)
   );

   always #5 slow_clk = ~slow_clk;

   task automatic add(input logic r, l, rt, h, b, input logic [NL-1:0] el, input logic ea);
      vec_t v;
      v.r = r; v.l = l; v.rt = rt; v.h = h; v.b = b; v.exp_led = el; v.exp_act = ea;
      vecs.push_back(v);
   endtask

   task automatic model_decide(input logic l, rt, h);
      m_t = 0;
      if (h || (l && rt)) m_mode = 3;
      else if (l)         m_mode = 1;
      else if (rt)        m_mode = 2;
      else                m_mode = 0;
   endtask

   task automatic model_step(input logic r, l, rt, h);
      if (r) begin
         m_mode = 0;
         m_t    = 0;
      end else if (m_mode == 0) begin
         model_decide(l, rt, h);
      end else if (m_mode == 1 || m_mode == 2) begin
         if (h || (l && rt)) begin
            m_mode = 3;
            m_t    = 0;
         end else if (m_t + 1 == SEG) begin
            m_mode = 0;
            m_t    = 0;
         end else begin
            m_t++;
         end
      end else begin
         if (m_t == HAZ_ON + HAZ_OFF - 1) model_decide(l, rt, h);
         else                             m_t++;
      end
   endtask

   function automatic logic [NL-1:0] model_led(input logic r, b);
      logic [NL-1:0] v;
      v = '0;
      if (!r) begin
         case (m_mode)
            0: v = b ? {NL{1'b1}} : '0;
            1: begin
               for (int p = 0; p < SEG; p++) begin
                  v[SEG + p]     = (p <= m_t);
                  v[SEG - 1 - p] = b;
               end
            end
            2: begin
               for (int p = 0; p < SEG; p++) begin
                  v[SEG - 1 - p] = (p <= m_t);
                  v[SEG + p]     = b;
               end
            end
            default: v = (m_t < HAZ_ON) ? {NL{1'b1}} : '0;
         endcase
      end
      return v;
   endfunction

   task automatic tick(input logic r, l, rt, h, b);
      @(negedge slow_clk);
      reset = r; left = l; right = rt; hazard = h; brake = b;
      @(posedge slow_clk);
      model_step(r, l, rt, h);
      #1;
   endtask

   task automatic check_led(input string name, input int idx, input logic [NL-1:0] act, exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s #%0d led actual %b required %b", name, idx, act, exp);
      end
   endtask

   task automatic check_act(input string name, input int idx, input logic act, exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s #%0d active actual %b required %b", name, idx, act, exp);
      end
   endtask

   initial begin
      logic r, l, rt, h, b;

      // reset
      add(1,0,0,0,0, 8'h00, 0);
      // left held 10 ticks
      for (int k = 0; k < 2; k++) begin
         add(0,1,0,0,0, 8'h10, 1);
         add(0,1,0,0,0, 8'h30, 1);
         add(0,1,0,0,0, 8'h70, 1);
         add(0,1,0,0,0, 8'hF0, 1);
         add(0,1,0,0,0, 8'h00, 0);
      end
      add(1,0,0,0,0, 8'h00, 0);
      // right single-tick pulse
      add(0,0,1,0,0, 8'h08, 1);
      add(0,0,0,0,0, 8'h0C, 1);
      add(0,0,0,0,0, 8'h0E, 1);
      add(0,0,0,0,0, 8'h0F, 1);
      add(0,0,0,0,0, 8'h00, 0);
      add(0,0,0,0,0, 8'h00, 0);
      // hazard held, then released in the final HOFF tick
      for (int k = 0; k < 2; k++) begin
         add(0,0,0,1,0, 8'hFF, 1);
         add(0,0,0,1,0, 8'hFF, 1);
         add(0,0,0,1,0, 8'h00, 1);
         add(0,0,0,1,0, 8'h00, 1);
      end
      add(0,0,0,0,0, 8'h00, 0);
      // left+right together behaves as hazard
      add(0,1,1,0,0, 8'hFF, 1);
      add(0,1,1,0,0, 8'hFF, 1);
      add(0,1,1,0,0, 8'h00, 1);
      add(0,1,1,0,0, 8'h00, 1);
      add(0,0,0,0,0, 8'h00, 0);
      // hazard pre-empts a left sweep; blink finishes after release
      add(0,1,0,0,0, 8'h10, 1);
      add(0,1,0,0,0, 8'h30, 1);
      add(0,1,0,1,0, 8'hFF, 1);
      add(0,0,0,1,0, 8'hFF, 1);
      add(0,0,0,1,0, 8'h00, 1);
      add(0,0,0,0,0, 8'h00, 1);
      add(0,0,0,0,0, 8'h00, 0);
      // brake with right held, then brake alone
      add(0,0,1,0,1, 8'hF8, 1);
      add(0,0,1,0,1, 8'hFC, 1);
      add(0,0,1,0,1, 8'hFE, 1);
      add(0,0,1,0,1, 8'hFF, 1);
      add(0,0,1,0,1, 8'hFF, 0);
      add(0,0,1,0,1, 8'hF8, 1);
      add(0,0,0,0,1, 8'hFC, 1);
      add(0,0,0,0,1, 8'hFE, 1);
      add(0,0,0,0,1, 8'hFF, 1);
      add(0,0,0,0,1, 8'hFF, 0);
      add(0,0,0,0,1, 8'hFF, 0);
      // reset mid-sweep, then restart
      add(0,1,0,0,0, 8'h10, 1);
      add(0,1,0,0,0, 8'h30, 1);
      add(0,1,0,0,0, 8'h70, 1);
      add(1,1,0,0,0, 8'h00, 0);
      add(0,1,0,0,0, 8'h10, 1);
      add(1,0,0,0,0, 8'h00, 0);
      // opposite request ignored until the sweep and its dark tick complete
      add(0,1,0,0,0, 8'h10, 1);
      add(0,0,1,0,0, 8'h30, 1);
      add(0,0,1,0,0, 8'h70, 1);
      add(0,0,1,0,0, 8'hF0, 1);
      add(0,0,1,0,0, 8'h00, 0);
      add(0,0,1,0,0, 8'h08, 1);

      for (int i = 0; i < vecs.size(); i++) begin
         tick(vecs[i].r, vecs[i].l, vecs[i].rt, vecs[i].h, vecs[i].b);
         check_led("vec", i, led, vecs[i].exp_led);
         check_act("vec", i, active, vecs[i].exp_act);
      end

      for (int i = 0; i < 3000; i++) begin
         r  = ($urandom_range(0, 63) == 0);
         l  = ($urandom_range(0, 3) == 0);
         rt = ($urandom_range(0, 3) == 0);
         h  = ($urandom_range(0, 9) == 0);
         b  = ($urandom_range(0, 2) == 0);
         tick(r, l, rt, h, b);
         check_led("rand", i, led, model_led(r, b));
         check_act("rand", i, active, (!r && m_mode != 0));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
